// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and defaults for the two-client RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef logic client_id_t;

    localparam client_id_t CLIENT0 = 1'b0;
    localparam client_id_t CLIENT1 = 1'b1;

    typedef struct packed {
        logic       valid;
        client_id_t id;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/ram_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_rr2
// Description : Combinational two-way round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  client_id_t last,
    output logic [1:0] gnt,
    output client_id_t gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = last;
        case (req)
            2'b01:   gnt_id = CLIENT0;
            2'b10:   gnt_id = CLIENT1;
            2'b11:   gnt_id = (last == CLIENT0) ? CLIENT1 : CLIENT0;
            default: gnt_id = last;
        endcase
        if (req != 2'b00) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_rw_arbiter
// Description : Round-robin sharing of a single-port RAM between two clients,
//               with registered command stage and tagged read return.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rw_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,

    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,

    output logic              ram_en,
    output logic              ram_wr_H_rd_L,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    client_id_t        w_gnt_id;
    logic              w_any_gnt;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    client_id_t        r_last;
    logic              r_ram_en;
    logic              r_ram_wr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    // Index 0 is aligned with the command stage; index RD_LAT with read data.
    rd_tag_t           r_tag [0:RD_LAT];

    assign w_req = {req_1, req_0};

    ram_arb_rr2 u_rr2 (
        .req    (w_req),
        .last   (r_last),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign gnt_0     = w_gnt[0];
    assign gnt_1     = w_gnt[1];
    assign w_any_gnt = |w_gnt;

    assign w_sel_we    = (w_gnt_id == CLIENT1) ? we_1    : we_0;
    assign w_sel_addr  = (w_gnt_id == CLIENT1) ? addr_1  : addr_0;
    assign w_sel_wdata = (w_gnt_id == CLIENT1) ? wdata_1 : wdata_0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= CLIENT1;
        end else if (w_any_gnt) begin
            r_last <= w_gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en    <= 1'b0;
            r_ram_wr    <= 1'b1;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_any_gnt) begin
            r_ram_en    <= 1'b1;
            r_ram_wr    <= w_sel_we;
            r_ram_addr  <= w_sel_addr;
            r_ram_wdata <= w_sel_wdata;
        end else begin
            r_ram_en    <= 1'b0;
            r_ram_wr    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_any_gnt && !w_sel_we;
            r_tag[0].id    <= w_gnt_id;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign ram_en        = r_ram_en;
    assign ram_wr_H_rd_L = r_ram_wr;
    assign ram_addr      = r_ram_addr;
    assign ram_wr_data   = r_ram_wdata;

    assign rvalid_0 = r_tag[RD_LAT].valid && (r_tag[RD_LAT].id == CLIENT0);
    assign rvalid_1 = r_tag[RD_LAT].valid && (r_tag[RD_LAT].id == CLIENT1);
    assign rdata_0  = ram_rd_data;
    assign rdata_1  = ram_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_rw_arbiter
// Description : Directed bench; RD_LAT=1 (a_) and RD_LAT=2 (b_) instances
//               share client stimulus, each with its own RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rw_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_0, we_0, req_1, we_1;
    logic [4:0] addr_0, addr_1;
    logic [7:0] wdata_0, wdata_1;

    logic       a_gnt_0, a_gnt_1, a_rv_0, a_rv_1, a_en, a_wr;
    logic [7:0] a_rd_0, a_rd_1, a_wd, a_rd;
    logic [4:0] a_addr;
    logic       b_gnt_0, b_gnt_1, b_rv_0, b_rv_1, b_en, b_wr;
    logic [7:0] b_rd_0, b_rd_1, b_wd, b_rd, b_stage;
    logic [4:0] b_addr;

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];

    int checks = 0;
    int errors = 0;

    ram_rw_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(a_gnt_0), .rvalid_0(a_rv_0), .rdata_0(a_rd_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(a_gnt_1), .rvalid_1(a_rv_1), .rdata_1(a_rd_1),
        .ram_en(a_en), .ram_wr_H_rd_L(a_wr), .ram_addr(a_addr),
        .ram_wr_data(a_wd), .ram_rd_data(a_rd)
    );

    ram_rw_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(b_gnt_0), .rvalid_0(b_rv_0), .rdata_0(b_rd_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(b_gnt_1), .rvalid_1(b_rv_1), .rdata_1(b_rd_1),
        .ram_en(b_en), .ram_wr_H_rd_L(b_wr), .ram_addr(b_addr),
        .ram_wr_data(b_wd), .ram_rd_data(b_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_en) begin
            if (a_wr) mem_a[a_addr] <= a_wd;
            else      a_rd <= mem_a[a_addr];
        end
    end

    always @(posedge clk) begin
        if (b_en) begin
            if (b_wr) mem_b[b_addr] <= b_wd;
            else      b_stage <= mem_b[b_addr];
        end
        b_rd <= b_stage;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_clients();
        req_0 = 1'b0; req_1 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_0 = 1'b0; we_0 = 1'b0; addr_0 = '0; wdata_0 = '0;
        req_1 = 1'b0; we_1 = 1'b0; addr_1 = '0; wdata_1 = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // ---- reset state ----
        @(negedge clk);
        check("rst_en_a",    a_en, 0);
        check("rst_wr_a",    a_wr, 1);
        check("rst_addr_a",  a_addr, 0);
        check("rst_wd_a",    a_wd, 0);
        check("rst_gnt_a",   {a_gnt_1, a_gnt_0}, 0);
        check("rst_rv_a",    {a_rv_1, a_rv_0}, 0);
        check("rst_rv_b",    {b_rv_1, b_rv_0}, 0);
        check("rst_en_b",    b_en, 0);

        // ---- contention: 8 cycles, both writing ----
        tick();
        req_0 = 1; we_0 = 1; addr_0 = 5'd20; wdata_0 = 8'h20;
        req_1 = 1; we_1 = 1; addr_1 = 5'd21; wdata_1 = 8'h21;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("cont_gnt0", a_gnt_0, (i % 2 == 0));
            check("cont_gnt1", a_gnt_1, (i % 2 == 1));
            @(negedge clk);
            if (i > 0) begin
                check("cont_en",   a_en, 1);
                check("cont_addr", a_addr, (i % 2 == 1) ? 20 : 21);
            end
            tick();
        end
        idle_clients();
        @(negedge clk);
        check("cont_en_last",   a_en, 1);
        check("cont_addr_last", a_addr, 21);
        tick();
        @(negedge clk);
        check("cont_en_off", a_en, 0);
        check("cont_addr_hold", a_addr, 21);
        check("cont_wr_idle", a_wr, 1);
        tick();

        // ---- write then read (both latencies) ----
        req_0 = 1; we_0 = 1; addr_0 = 5'd5; wdata_0 = 8'hA5;
        @(negedge clk);
        check("wr_gnt0", a_gnt_0, 1);
        check("wr_gnt1", a_gnt_1, 0);
        tick();
        req_0 = 0;
        req_1 = 1; we_1 = 0; addr_1 = 5'd5;
        @(negedge clk);
        check("wr_en",   a_en, 1);
        check("wr_wr",   a_wr, 1);
        check("wr_addr", a_addr, 5);
        check("wr_data", a_wd, 8'hA5);
        check("rd_gnt1", a_gnt_1, 1);
        tick();
        idle_clients();
        @(negedge clk);
        check("rd_en",  a_en, 1);
        check("rd_wr",  a_wr, 0);
        check("rd_rv_early", a_rv_1, 0);
        tick();
        @(negedge clk);
        check("rd_rv1_a",   a_rv_1, 1);
        check("rd_data1_a", a_rd_1, 8'hA5);
        check("rd_rv0_a",   a_rv_0, 0);
        check("rd_rv1_b_early", b_rv_1, 0);
        tick();
        @(negedge clk);
        check("rd_rv1_a_done", a_rv_1, 0);
        check("rd_rv1_b",   b_rv_1, 1);
        check("rd_data1_b", b_rd_1, 8'hA5);
        check("rd_rv0_b",   b_rv_0, 0);
        tick();
        @(negedge clk);
        check("rd_rv1_b_done", b_rv_1, 0);
        tick();

        // ---- streaming: write k+1 to k, then read 0..31 back-to-back ----
        for (int k = 0; k < 32; k++) begin
            req_0 = 1; we_0 = 1; addr_0 = 5'(k); wdata_0 = 8'(k + 1);
            tick();
        end
        for (int i = 0; i < 36; i++) begin
            if (i < 32) begin
                req_0 = 1; we_0 = 0; addr_0 = 5'(i);
            end else begin
                req_0 = 0;
            end
            @(negedge clk);
            check("str_rv_a", a_rv_0, (i >= 2 && i < 34));
            if (i >= 2 && i < 34) check("str_data_a", a_rd_0, i - 1);
            check("str_rv_b", b_rv_0, (i >= 3 && i < 35));
            if (i >= 3 && i < 35) check("str_data_b", b_rd_0, i - 2);
            check("str_rv1", {a_rv_1, b_rv_1}, 0);
            tick();
        end

        // ---- interleaved reads: last=0, so client 1 wins the tie ----
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                req_0 = 1; we_0 = 0; addr_0 = 5'd3;
                req_1 = 1; we_1 = 0; addr_1 = 5'd7;
            end else if (i == 1) begin
                req_1 = 0;
            end else begin
                req_0 = 0;
            end
            @(negedge clk);
            if (i == 0) check("il_gnt", {a_gnt_1, a_gnt_0}, 2'b10);
            if (i == 1) check("il_gnt", {a_gnt_1, a_gnt_0}, 2'b01);
            check("il_rv_a", {a_rv_1, a_rv_0}, (i == 2) ? 2'b10 : (i == 3) ? 2'b01 : 2'b00);
            check("il_rv_b", {b_rv_1, b_rv_0}, (i == 3) ? 2'b10 : (i == 4) ? 2'b01 : 2'b00);
            if (i == 2) check("il_data_a1", a_rd_1, 8'h08);
            if (i == 3) check("il_data_a0", a_rd_0, 8'h04);
            if (i == 3) check("il_data_b1", b_rd_1, 8'h08);
            if (i == 4) check("il_data_b0", b_rd_0, 8'h04);
            tick();
        end

        // ---- reset while a read is in flight ----
        req_0 = 1; we_0 = 0; addr_0 = 5'd9;
        tick();
        req_0 = 0;
        check("mid_en_before", a_en, 1);
        rst_n = 1'b0;
        #1;
        check("mid_en_async_a", a_en, 0);
        check("mid_en_async_b", b_en, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_rv_a", {a_rv_1, a_rv_0}, 0);
            check("mid_rv_b", {b_rv_1, b_rv_0}, 0);
            check("mid_en",   a_en, 0);
            check("mid_addr", a_addr, 0);
            check("mid_wr",   a_wr, 1);
            tick();
        end
        req_0 = 1; we_0 = 0; addr_0 = 5'd1;
        req_1 = 1; we_1 = 0; addr_1 = 5'd2;
        #1;
        check("mid_ptr_gnt", {a_gnt_1, a_gnt_0}, 2'b01);
        tick();
        idle_clients();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
